// File: rtl/timestamp_event_capture.sv
// timestamp_event_capture
// Synchronises an asynchronous event pin, detects the selected edge(s) and
// snapshots the sec/msec/usec timer into a first-word-fall-through FIFO that
// is drained through a valid/ready interface. FIFO overflows are counted in a
// saturating dropped-event counter.
// Optional feature: define EVT_DEBOUNCE_EN to insert a debounce filter
// between the synchroniser and the edge detector.
module timestamp_event_capture #(
    parameter int DEPTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk_200mhz,
    input  logic                   reset,
    input  logic [31:0]            sec,
    input  logic [15:0]            msec,
    input  logic [15:0]            usec,
    input  logic                   evt_in,
    input  logic [1:0]             edge_sel,
    output logic                   ts_valid,
    input  logic                   ts_ready,
    output logic [31:0]            ts_sec,
    output logic [15:0]            ts_msec,
    output logic [15:0]            ts_usec,
    output logic                   ts_rise,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            ovf_cnt,
    input  logic                   ovf_clr
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_level;
    logic                   w_level;

    // Shift the asynchronous pin through the synchroniser chain
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], evt_in};
        end
    end

    assign w_sync_level = r_sync[SYNC_STAGES-1];

`ifdef EVT_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    localparam int DB_LEN = DEBOUNCE_CYCLES;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;

    // Accept a new level once it has differed from the accepted one for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (w_sync_level == r_db_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_level <= w_sync_level;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_db_level;
`else
    localparam int DB_LEN = 0;

    assign w_level = w_sync_level;
`endif

    // ------------------------------------------------------------------
    // Arming FSM: edge detection is held off after reset until the
    // synchroniser (and debounce filter) reflect the real pin level
    // ------------------------------------------------------------------
    localparam int ARM_LEN = SYNC_STAGES + 1 + DB_LEN;
    localparam int ARM_W   = $clog2(ARM_LEN + 1);

    typedef enum logic {
        ST_ARMING,
        ST_ARMED
    } arm_state_t;

    arm_state_t       r_state;
    arm_state_t       w_state_nxt;
    logic [ARM_W-1:0] r_arm_cnt;
    logic [ARM_W-1:0] w_arm_cnt_nxt;
    logic             w_armed;

    // Arming state and window counter registers
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_state   <= ST_ARMING;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
        end
    end

    // Arming next-state logic: count out the arming window, then stay armed
    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        w_armed       = 1'b0;
        case (r_state)
            ST_ARMING: begin
                if (r_arm_cnt == ARM_W'(ARM_LEN - 1)) begin
                    w_state_nxt   = ST_ARMED;
                    w_arm_cnt_nxt = '0;
                end else begin
                    w_arm_cnt_nxt = r_arm_cnt + 1'b1;
                end
            end
            ST_ARMED: begin
                w_armed = 1'b1;
            end
            default: begin
                w_state_nxt = ST_ARMING;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic r_prev;
    logic r_rise_det;
    logic r_fall_det;
    logic w_push_req;

    // Previous level always tracks; raw edge flags only once armed
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_prev     <= 1'b0;
            r_rise_det <= 1'b0;
            r_fall_det <= 1'b0;
        end else begin
            r_prev     <= w_level;
            r_rise_det <= w_armed & w_level & ~r_prev;
            r_fall_det <= w_armed & ~w_level & r_prev;
        end
    end

    // Raw edges are registered; edge_sel qualifies them in the capture cycle,
    // so the timer value and edge_sel are sampled in the same cycle.
    assign w_push_req = (r_rise_det & edge_sel[0]) | (r_fall_det & edge_sel[1]);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]      r_mem_sec  [DEPTH];
    logic [15:0]      r_mem_msec [DEPTH];
    logic [15:0]      r_mem_usec [DEPTH];
    logic             r_mem_rise [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_level_cnt;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_level_cnt = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_level_cnt == '0);
    assign w_full      = (w_level_cnt == PTR_W'(DEPTH));
    assign w_pop       = ~w_empty & ts_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;

    // FIFO pointer update
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage write: timer snapshot plus edge polarity
    always_ff @(posedge clk_200mhz) begin
        if (w_push) begin
            r_mem_sec[r_wr_ptr[ADDR_W-1:0]]  <= sec;
            r_mem_msec[r_wr_ptr[ADDR_W-1:0]] <= msec;
            r_mem_usec[r_wr_ptr[ADDR_W-1:0]] <= usec;
            r_mem_rise[r_wr_ptr[ADDR_W-1:0]] <= r_rise_det;
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        ts_valid = 1'b0;
        ts_sec   = '0;
        ts_msec  = '0;
        ts_usec  = '0;
        ts_rise  = 1'b0;
        if (!w_empty) begin
            ts_valid = 1'b1;
            ts_sec   = r_mem_sec[r_rd_ptr[ADDR_W-1:0]];
            ts_msec  = r_mem_msec[r_rd_ptr[ADDR_W-1:0]];
            ts_usec  = r_mem_usec[r_rd_ptr[ADDR_W-1:0]];
            ts_rise  = r_mem_rise[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    assign fifo_level = w_level_cnt;

    // ------------------------------------------------------------------
    // Dropped-event counter
    // ------------------------------------------------------------------
    logic [15:0] r_ovf_cnt;

    // Saturating drop counter; a clear coinciding with a drop leaves a count of 1
    always_ff @(posedge clk_200mhz) begin
        if (reset) begin
            r_ovf_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf_cnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && r_ovf_cnt != 16'hFFFF) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_timestamp_event_capture.sv
// Self-checking bench for timestamp_event_capture: table-driven single-edge
// captures plus hand-written sequences for both-edge, overflow, full with
// simultaneous pop, reset mid-operation and (when EVT_DEBOUNCE_EN) debounce.
module tb_timestamp_event_capture;

    localparam int DEPTH = 8;
`ifdef EVT_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic        clk_200mhz = 1'b0;
    logic        reset;
    logic [31:0] sec;
    logic [15:0] msec;
    logic [15:0] usec;
    logic        evt_in;
    logic [1:0]  edge_sel;
    logic        ts_valid;
    logic        ts_ready;
    logic [31:0] ts_sec;
    logic [15:0] ts_msec;
    logic [15:0] ts_usec;
    logic        ts_rise;
    logic [3:0]  fifo_level;
    logic [15:0] ovf_cnt;
    logic        ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_200mhz = ~clk_200mhz;

    timestamp_event_capture #(
        .DEPTH          (DEPTH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_200mhz(clk_200mhz),
        .reset     (reset),
        .sec       (sec),
        .msec      (msec),
        .usec      (usec),
        .evt_in    (evt_in),
        .edge_sel  (edge_sel),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .ts_sec    (ts_sec),
        .ts_msec   (ts_msec),
        .ts_usec   (ts_usec),
        .ts_rise   (ts_rise),
        .fifo_level(fifo_level),
        .ovf_cnt   (ovf_cnt),
        .ovf_clr   (ovf_clr)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        start;
        logic [31:0] sec;
        logic [15:0] msec;
        logic [15:0] usec;
        logic        exp_valid;
        logic        exp_rise;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_200mhz);
        #1;
    endtask

    task automatic pop_one;
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
    endtask

    // One rising pulse; optionally assert ovf_clr / ts_ready exactly in the capture cycle
    task automatic pulse_evt(input logic [31:0] s, input logic clr, input logic rdy);
        sec    = s;
        usec   = s[15:0];
        evt_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == LAT - 1) begin
                ovf_clr  = clr;
                ts_ready = rdy;
            end
            if (k == LAT) begin
                ovf_clr  = 1'b0;
                ts_ready = 1'b0;
            end
            if (k == 5) evt_in = 1'b0;
        end
    endtask

    // Bound the whole run
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b01, 1'b0, 32'd5,          16'd123, 16'd400, 1'b1, 1'b1};
        vecs[1] = '{2'b01, 1'b1, 32'd6,          16'd1,   16'd2,   1'b0, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 32'd7,          16'd999, 16'd999, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 1'b0, 32'd8,          16'd0,   16'd0,   1'b0, 1'b0};
        vecs[4] = '{2'b11, 1'b0, 32'hFFFF_FFFF,  16'd500, 16'd1,   1'b1, 1'b1};
        vecs[5] = '{2'b11, 1'b1, 32'd9,          16'd42,  16'd7,   1'b1, 1'b0};
        vecs[6] = '{2'b00, 1'b0, 32'd10,         16'd3,   16'd4,   1'b0, 1'b0};

        reset    = 1'b1;
        sec      = 32'h1234;
        msec     = 16'd11;
        usec     = 16'd22;
        evt_in   = 1'b0;
        edge_sel = 2'b00;
        ts_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", ts_valid, 0);
        chk("rst_sec", ts_sec, 0);
        chk("rst_rise", ts_rise, 0);
        chk("rst_ovf", ovf_cnt, 0);
        reset = 1'b0;

        // Table-driven single-transition captures
        for (int i = 0; i < NV; i++) begin
            edge_sel = 2'b00;
            evt_in   = vecs[i].start;
            repeat (LAT + 4) tick();
            edge_sel = vecs[i].sel;
            repeat (2) tick();
            chk($sformatf("v%0d_selchg_level", i), fifo_level, 0);
            sec    = vecs[i].sec;
            msec   = vecs[i].msec;
            usec   = vecs[i].usec;
            evt_in = ~vecs[i].start;
            repeat (LAT - 1) tick();
            chk($sformatf("v%0d_early_valid", i), ts_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), ts_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_level", i), fifo_level, vecs[i].exp_valid ? 1 : 0);
            chk($sformatf("v%0d_sec", i), ts_sec, vecs[i].exp_valid ? vecs[i].sec : 0);
            chk($sformatf("v%0d_msec", i), ts_msec, vecs[i].exp_valid ? vecs[i].msec : 0);
            chk($sformatf("v%0d_usec", i), ts_usec, vecs[i].exp_valid ? vecs[i].usec : 0);
            chk($sformatf("v%0d_rise", i), ts_rise, vecs[i].exp_valid ? vecs[i].exp_rise : 0);
            pop_one();
            chk($sformatf("v%0d_after_pop", i), fifo_level, 0);
        end

        // Both edges with a running timer: usec advances by one per cycle
        edge_sel = 2'b00;
        evt_in   = 1'b0;
        repeat (LAT + 4) tick();
        edge_sel = 2'b11;
        sec      = 32'd20;
        msec     = 16'd0;
        usec     = 16'd500;
        evt_in   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            usec = 16'(500 + k);
            if (k == 10) evt_in = 1'b0;
        end
        chk("both_level", fifo_level, 2);
        chk("both_r_rise", ts_rise, 1);
        chk("both_r_usec", ts_usec, 500 + LAT - 1);
        pop_one();
        chk("both_f_rise", ts_rise, 0);
        chk("both_f_usec", ts_usec, 510 + LAT - 1);
        pop_one();
        chk("both_empty", fifo_level, 0);

        // Overflow: 11 rising events into an 8-deep FIFO with no consumer
        edge_sel = 2'b01;
        msec     = 16'd0;
        for (int i = 0; i < 11; i++) pulse_evt(32'(100 + i), 1'b0, 1'b0);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_cnt3", ovf_cnt, 3);
        chk("ovf_head_stable", ts_sec, 100);
        pulse_evt(32'd111, 1'b1, 1'b0);
        chk("ovf_clr_with_drop", ovf_cnt, 1);
        chk("ovf_clr_drop_level", fifo_level, 8);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", ovf_cnt, 0);

        // Full with simultaneous pop: push accepted at the tail
        pulse_evt(32'd200, 1'b0, 1'b1);
        chk("fullpop_level", fifo_level, 8);
        chk("fullpop_ovf", ovf_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_sec", i), ts_sec, (i < 7) ? 101 + i : 200);
            chk($sformatf("drain%0d_rise", i), ts_rise, 1);
            pop_one();
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_valid", ts_valid, 0);
        chk("drain_sec_zero", ts_sec, 0);
        pop_one();
        chk("ready_empty_level", fifo_level, 0);

        // Reset mid-operation with the pin held high across reset release
        for (int i = 0; i < 9; i++) pulse_evt(32'(300 + i), 1'b0, 1'b0);
        chk("prerst_level", fifo_level, 8);
        chk("prerst_ovf", ovf_cnt, 1);
        evt_in = 1'b1;
        reset  = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("midrst_level", fifo_level, 0);
        chk("midrst_valid", ts_valid, 0);
        chk("midrst_ovf", ovf_cnt, 0);
        edge_sel = 2'b11;
        repeat (20) tick();
        chk("midrst_no_evt", fifo_level, 0);
        sec    = 32'd400;
        evt_in = 1'b0;
        repeat (LAT) tick();
        chk("rearm_valid", ts_valid, 1);
        chk("rearm_rise", ts_rise, 0);
        chk("rearm_sec", ts_sec, 400);
        pop_one();

`ifdef EVT_DEBOUNCE_EN
        // Debounce: 3-cycle pulse filtered, 4-cycle pulse accepted both ways
        repeat (10) tick();
        evt_in = 1'b1;
        repeat (3) tick();
        evt_in = 1'b0;
        repeat (20) tick();
        chk("db_short_level", fifo_level, 0);
        evt_in = 1'b1;
        repeat (4) tick();
        evt_in = 1'b0;
        repeat (20) tick();
        chk("db_long_level", fifo_level, 2);
        chk("db_long_rise", ts_rise, 1);
        pop_one();
        chk("db_long_fall", ts_rise, 0);
        pop_one();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
